// File: rtl/interval_timer.sv
// Programmable interval timer with a built-in prescaler.
// One-shot or periodic; start/stop/pause control and a one-cycle done pulse.
module interval_timer #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned PRE_W    = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [WIDTH-1:0] target,
    output logic             busy,
    output logic             held,
    output logic             done,
    output logic [WIDTH-1:0] elapsed
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] elapsed_q, elapsed_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             held_q, held_d;

    // Next-state: start > stop > pause > count
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        elapsed_d = elapsed_q;
        target_d  = target_q;
        mode_d    = mode_q;
        done_d    = 1'b0;

        if (start) begin
            target_d  = target;
            mode_d    = periodic;
            pre_d     = '0;
            elapsed_d = '0;
            if (target == '0) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = RUN;
            end
        end else if (stop) begin
            state_d = IDLE;
            pre_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (elapsed_q + WIDTH'(1) == target_q) begin
                            done_d = 1'b1;
                            if (mode_q) begin
                                elapsed_d = '0;
                            end else begin
                                elapsed_d = target_q;
                                state_d   = IDLE;
                            end
                        end else begin
                            elapsed_d = elapsed_q + WIDTH'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                HOLD: begin
                    if (!pause) state_d = RUN;
                end
                default: ;
            endcase
        end

        busy_d = (state_d != IDLE);
        held_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            elapsed_q <= '0;
            target_q  <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            elapsed_q <= elapsed_d;
            target_q  <= target_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            held_q    <= held_d;
        end
    end

    assign busy    = busy_q;
    assign held    = held_q;
    assign done    = done_q;
    assign elapsed = elapsed_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: one instance with PRESCALE=4, one with PRESCALE=1.
module tb_interval_timer;

    logic       clk;
    logic       reset;
    logic       start, stop, pause, periodic;
    logic [9:0] target;

    logic       busy4, held4, done4;
    logic [9:0] el4;
    logic       busy1, held1, done1;
    logic [9:0] el1;

    int n_cmp = 0;
    int n_err = 0;

    interval_timer #(.WIDTH(10), .PRESCALE(4), .PRE_W(26)) dut4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .periodic(periodic), .target(target),
        .busy(busy4), .held(held4), .done(done4), .elapsed(el4)
    );

    interval_timer #(.WIDTH(10), .PRESCALE(1), .PRE_W(26)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .periodic(periodic), .target(target),
        .busy(busy1), .held(held1), .done(done1), .elapsed(el1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic        pause;
        logic        periodic;
        logic [9:0]  target;
        int unsigned edges;
        logic        e_done;
        logic        e_busy;
        logic        e_held;
        logic [9:0]  e_el;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic st, input logic pa, input logic per,
                                input logic [9:0] tgt, input int unsigned n,
                                input logic d, input logic b, input logic h, input logic [9:0] el);
        vec_t v;
        v.start = s; v.stop = st; v.pause = pa; v.periodic = per; v.target = tgt;
        v.edges = n; v.e_done = d; v.e_busy = b; v.e_held = h; v.e_el = el;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic st, input logic pa, input logic per,
                         input logic [9:0] tgt);
        start = s; stop = st; pause = pa; periodic = per; target = tgt;
    endtask

    initial begin
        drive(0, 0, 0, 0, 10'd0);
        reset = 1'b0;
        #12;
        chk("rst.busy", 32'(busy4), 32'd0);
        chk("rst.held", 32'(held4), 32'd0);
        chk("rst.done", 32'(done4), 32'd0);
        chk("rst.elapsed", 32'(el4), 32'd0);
        #1 reset = 1'b1;
        step();

        // one-shot, target 3: done at edge 12; target/periodic changes mid-run ignored
        add(1,0,0,0,10'd3,1, 0,1,0,10'd0);
        add(0,0,0,0,10'd0,3, 0,1,0,10'd0);
        add(0,0,0,0,10'd0,1, 0,1,0,10'd1);
        add(0,0,0,1,10'd5,7, 0,1,0,10'd2);
        add(0,0,0,0,10'd0,1, 1,0,0,10'd3);
        add(0,0,0,0,10'd0,1, 0,0,0,10'd3);
        add(0,0,0,0,10'd0,5, 0,0,0,10'd3);
        // periodic, target 2: done at 8 and 16, stop after edge 20
        add(1,0,0,1,10'd2,1, 0,1,0,10'd0);
        add(0,0,0,0,10'd7,8, 1,1,0,10'd0);
        add(0,0,0,0,10'd0,1, 0,1,0,10'd0);
        add(0,0,0,0,10'd0,3, 0,1,0,10'd1);
        add(0,0,0,0,10'd0,3, 0,1,0,10'd1);
        add(0,0,0,0,10'd0,1, 1,1,0,10'd0);
        add(0,0,0,0,10'd0,4, 0,1,0,10'd1);
        add(0,1,0,0,10'd0,1, 0,0,0,10'd1);
        add(0,0,0,0,10'd0,3, 0,0,0,10'd1);
        // pause on edges 5-9, resume edge 10, done at 18
        add(1,0,0,0,10'd3,1, 0,1,0,10'd0);
        add(0,0,0,0,10'd0,4, 0,1,0,10'd1);
        add(0,0,1,0,10'd0,1, 0,1,1,10'd1);
        add(0,0,1,0,10'd0,4, 0,1,1,10'd1);
        add(0,0,0,0,10'd0,1, 0,1,0,10'd1);
        add(0,0,0,0,10'd0,3, 0,1,0,10'd1);
        add(0,0,0,0,10'd0,1, 0,1,0,10'd2);
        add(0,0,0,0,10'd0,3, 0,1,0,10'd2);
        add(0,0,0,0,10'd0,1, 1,0,0,10'd3);
        // restart at edge 6 with target 2: no done at 12, done at 14
        add(1,0,0,0,10'd3,1, 0,1,0,10'd0);
        add(0,0,0,0,10'd0,5, 0,1,0,10'd1);
        add(1,0,0,0,10'd2,1, 0,1,0,10'd0);
        add(0,0,0,0,10'd0,5, 0,1,0,10'd1);
        add(0,0,0,0,10'd0,1, 0,1,0,10'd1);
        add(0,0,0,0,10'd0,2, 1,0,0,10'd2);
        // target 0 in both modes, from IDLE and from RUN; pause while idle
        add(1,0,0,0,10'd0,1, 1,0,0,10'd0);
        add(0,0,0,0,10'd0,1, 0,0,0,10'd0);
        add(0,0,0,0,10'd0,4, 0,0,0,10'd0);
        add(1,0,0,1,10'd0,1, 1,0,0,10'd0);
        add(0,0,0,0,10'd0,1, 0,0,0,10'd0);
        add(1,0,0,0,10'd3,1, 0,1,0,10'd0);
        add(0,0,0,0,10'd0,6, 0,1,0,10'd1);
        add(1,0,0,0,10'd0,1, 1,0,0,10'd0);
        add(0,0,0,0,10'd0,8, 0,0,0,10'd0);
        add(0,0,1,0,10'd0,2, 0,0,0,10'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].periodic, vecs[i].target);
            for (int k = 0; k < int'(vecs[i].edges); k++) step();
            chk($sformatf("row%0d.done", i),    32'(done4), 32'(vecs[i].e_done));
            chk($sformatf("row%0d.busy", i),    32'(busy4), 32'(vecs[i].e_busy));
            chk($sformatf("row%0d.held", i),    32'(held4), 32'(vecs[i].e_held));
            chk($sformatf("row%0d.elapsed", i), 32'(el4),   32'(vecs[i].e_el));
        end
        drive(0, 0, 0, 0, 10'd0);

        // asynchronous reset between edges while running
        drive(1, 0, 0, 0, 10'd3);
        step();
        drive(0, 0, 0, 0, 10'd0);
        repeat (5) step();
        chk("pre_arst.busy", 32'(busy4), 32'd1);
        chk("pre_arst.elapsed", 32'(el4), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst.busy", 32'(busy4), 32'd0);
        chk("arst.elapsed", 32'(el4), 32'd0);
        chk("arst.done", 32'(done4), 32'd0);
        #2 reset = 1'b1;
        repeat (4) step();
        chk("post_arst.busy", 32'(busy4), 32'd0);
        chk("post_arst.elapsed", 32'(el4), 32'd0);
        chk("post_arst.done", 32'(done4), 32'd0);

        // asynchronous reset kills a done pulse in flight
        drive(1, 0, 0, 1, 10'd2);
        step();
        drive(0, 0, 0, 0, 10'd0);
        repeat (8) step();
        chk("pre_arst2.done", 32'(done4), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst2.done", 32'(done4), 32'd0);
        chk("arst2.busy", 32'(busy4), 32'd0);
        #2 reset = 1'b1;

        // start and stop on the same edge: start wins
        drive(1, 1, 0, 0, 10'd3);
        step();
        drive(0, 0, 0, 0, 10'd0);
        chk("startstop.busy", 32'(busy4), 32'd1);
        chk("startstop.elapsed", 32'(el4), 32'd0);
        repeat (12) step();
        chk("startstop.done", 32'(done4), 32'd1);
        chk("startstop.elapsed_end", 32'(el4), 32'd3);

        // PRESCALE=1, maximum target
        drive(1, 0, 0, 0, 10'd1023);
        step();
        drive(0, 0, 0, 0, 10'd0);
        repeat (1022) step();
        chk("max.done_early", 32'(done1), 32'd0);
        chk("max.elapsed_early", 32'(el1), 32'd1022);
        chk("max.busy_early", 32'(busy1), 32'd1);
        step();
        chk("max.done", 32'(done1), 32'd1);
        chk("max.elapsed", 32'(el1), 32'd1023);
        chk("max.busy", 32'(busy1), 32'd0);
        chk("max.held", 32'(held1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
Parametrised successor to the team's fixed seconds counter. It is a programmable interval timer with a built-in prescaler, so it runs from the system clock instead of a separate 1 Hz clock. It supports one-shot and periodic modes, start/stop/pause control, a latched target, and a single-cycle done pulse. It drives the airlock/chamber sequencing FSMs that need 5/7/8-minute-style delays.

Parameters:
WIDTH, 10, width of target and elapsed-unit count (max interval 2^WIDTH-1 units)
PRESCALE, 1, clk cycles per counted unit (50_000_000 for 1 s at 50 MHz; 1 means one unit per clk)
PRE_W, 26, prescaler register width; must satisfy 2^PRE_W >= PRESCALE

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  level sampled each edge; latch target, clear counts, begin timing
stop  input  1  abort timing, return to IDLE, no done
pause  input  1  level; freeze counting while high
periodic  input  1  sampled with start; 1 = auto-reload, 0 = one-shot
target  input  WIDTH  interval length in units; sampled only when start is accepted
busy  output  1  high in RUN or HOLD
held  output  1  high in HOLD
done  output  1  one-clk pulse when elapsed reaches target
elapsed  output  WIDTH  units counted since start or last reload

Behaviour:
- States: IDLE, RUN, HOLD. busy = (state != IDLE); held = (state == HOLD). Both are registered and decoded from state.
- Reset (reset = 0, asynchronous, takes effect immediately): state IDLE, prescaler 0, elapsed 0, target_q 0, mode_q 0, done 0, busy 0, held 0.
- Per-edge priority: start > stop > pause > count.
- start accepted (any state):
  - target_q <= target, mode_q <= periodic, prescaler <= 0, elapsed <= 0.
  - If target == 0: done = 1 for that one cycle and state stays IDLE, in either mode.
  - Otherwise state <= RUN.
- stop (no start): state <= IDLE. elapsed holds its value, prescaler cleared, no done.
- RUN with pause sampled high: state <= HOLD. No increment on that edge.
- HOLD with pause low: state <= RUN. No increment on that edge (one-edge resume cost).
- HOLD with pause high: state stays HOLD. All counts frozen.
- RUN counting edge (pause low):
  - If prescaler == PRESCALE-1: prescaler <= 0 and a unit tick occurs. Otherwise prescaler <= prescaler + 1.
  - PRESCALE = 1 means a tick on every counting edge.
- On a tick:
  - If elapsed + 1 == target_q (WIDTH-bit compare; cannot overflow because counting stops at target_q): done <= 1.
    - One-shot: elapsed <= target_q, state <= IDLE.
    - Periodic: elapsed <= 0, stay RUN, with no dead cycle between periods.
  - Otherwise elapsed <= elapsed + 1.
- done is registered, high exactly one cycle, and otherwise 0.
- Latency: start sampled at edge k with no pause gives done high after edge k + N*PRESCALE (N = target). Periodic pulses then repeat every N*PRESCALE edges.
- target and periodic changes while busy are ignored until the next accepted start.
- start while RUN/HOLD restarts cleanly; any pending done from the old interval is discarded.

Test Plan:
1. PRESCALE=4, WIDTH=10, one-shot, target=3, start at edge 0 -> done high only after edge 12; elapsed=3; busy falls at edge 12; elapsed stays 3 afterwards.
2. PRESCALE=4, periodic, target=2, start at edge 0 -> done at edges 8, 16; elapsed cycles 0,1,0,1; stop at edge 20 -> busy 0, no done at 24, elapsed holds 1.
3. PRESCALE=4, one-shot, target=3, start at edge 0, pause high sampled edges 5-9 -> held=1 during edges 5-9; resume costs edge 10; done at edge 18, not 12.
4. target=0 with start -> done high for the one cycle after the start edge, busy never asserts. Also PRESCALE=1, target=1023 -> done after edge 1023 and elapsed=1023.
5. PRESCALE=4, target=3, start at edge 0, restart at edge 6 with target=2 -> no done at 12; done at edge 14.
6. Drive reset low asynchronously mid-RUN (between edges) -> busy, done, elapsed go 0 before the next clk edge; after reset goes high, no activity until start; start and stop on the same edge -> start wins, busy=1.
